// File: rtl/fpu_pkg.sv
// Shared types and unit index constants for the FPU dispatcher.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } fpu_state_t;

    localparam int FPU_ADD       = 0;
    localparam int FPU_SUB       = 1;
    localparam int FPU_MUL       = 2;
    localparam int FPU_DIV       = 3;
    localparam int FPU_SQRT      = 4;
    localparam int FPU_ABS       = 5;
    localparam int FPU_CMP       = 6;
    localparam int FPU_FTOI      = 7;
    localparam int FPU_ITOF      = 8;
    localparam int FPU_NUM_UNITS = 9;

endpackage

// File: rtl/fpu_dispatch_if.sv
// Core request/response and per-unit issue/result signals of the FPU dispatcher.
// slave: the dispatcher side; master: the core plus attached units.
interface fpu_dispatch_if #(
    parameter int NUM_UNITS = 9,
    parameter int DATA_W    = 32
);
    logic                        req_valid;
    logic                        req_ready;
    logic [NUM_UNITS-1:0]        req_op;
    logic [NUM_UNITS-1:0]        unit_in_valid;
    logic [NUM_UNITS-1:0]        unit_in_ready;
    logic [NUM_UNITS-1:0]        unit_out_valid;
    logic [NUM_UNITS*DATA_W-1:0] unit_out_data;
    logic                        res_valid;
    logic                        res_ready;
    logic [DATA_W-1:0]           res_data;
    logic                        res_err;
    logic                        busy;

    modport slave (
        input  req_valid, req_op, unit_in_ready, unit_out_valid, unit_out_data, res_ready,
        output req_ready, unit_in_valid, res_valid, res_data, res_err, busy
    );

    modport master (
        output req_valid, req_op, unit_in_ready, unit_out_valid, unit_out_data, res_ready,
        input  req_ready, unit_in_valid, res_valid, res_data, res_err, busy
    );
endinterface

// File: rtl/fpu_onehot_enc.sv
// One-hot to binary encoder with a validity flag; idx is meaningful only when is_onehot=1.
module fpu_onehot_enc #(
    parameter int N     = 9,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot
);
    logic [IDX_W-1:0] masked [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign masked[gi] = vec[gi] ? IDX_W'(gi) : '0;
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = idx | masked[i];
        end
    end

    // Clearing the lowest set bit leaves zero only for a single set bit.
    assign is_onehot = (vec != '0) && ((vec & (vec - 1'b1)) == '0);
endmodule

// File: rtl/fpu_dispatch.sv
// Single-outstanding FPU front end: issues one request to the unit selected by a one-hot
// opcode and returns its result. Optional issue-to-result timeout: FPU_DISPATCH_TIMEOUT_EN.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int NUM_UNITS      = FPU_NUM_UNITS,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic          clk,
    input logic          rst,
    fpu_dispatch_if.slave bus
);
    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    fpu_state_t           state_reg, state_next;
    logic [NUM_UNITS-1:0] sel_reg, sel_next;
    logic [NUM_UNITS-1:0] unit_in_valid_reg, unit_in_valid_next;
    logic                 res_valid_reg, res_valid_next;
    logic [DATA_W-1:0]    res_data_reg, res_data_next;
    logic                 res_err_reg, res_err_next;

    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_onehot_unused;
    logic [IDX_W-1:0]     req_idx_unused;
    logic                 req_onehot;
    logic [DATA_W-1:0]    slice [NUM_UNITS];
    logic                 sel_out_valid;
    logic                 sel_in_ready;
    logic                 timeout_hit;

    fpu_onehot_enc #(.N(NUM_UNITS), .IDX_W(IDX_W)) u_req_enc (
        .vec       (bus.req_op),
        .idx       (req_idx_unused),
        .is_onehot (req_onehot)
    );

    fpu_onehot_enc #(.N(NUM_UNITS), .IDX_W(IDX_W)) u_sel_enc (
        .vec       (sel_reg),
        .idx       (sel_idx),
        .is_onehot (sel_onehot_unused)
    );

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slice
            assign slice[gi] = bus.unit_out_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Handshakes from units other than the latched one never reach the FSM.
    assign sel_out_valid = |(bus.unit_out_valid & sel_reg);
    assign sel_in_ready  = |(bus.unit_in_ready & sel_reg);

`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == IDLE) begin
            cnt_next = '0;
        end else if ((state_reg == ISSUE) || (state_reg == WAIT)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            sel_reg           <= '0;
            unit_in_valid_reg <= '0;
            res_valid_reg     <= 1'b0;
            res_data_reg      <= '0;
            res_err_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            sel_reg           <= sel_next;
            unit_in_valid_reg <= unit_in_valid_next;
            res_valid_reg     <= res_valid_next;
            res_data_reg      <= res_data_next;
            res_err_reg       <= res_err_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        sel_next           = sel_reg;
        unit_in_valid_next = unit_in_valid_reg;
        res_valid_next     = res_valid_reg;
        res_data_next      = res_data_reg;
        res_err_next       = res_err_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    sel_next = bus.req_op;
                    if (req_onehot) begin
                        unit_in_valid_next = bus.req_op;
                        state_next         = ISSUE;
                    end else begin
                        res_valid_next = 1'b1;
                        res_err_next   = 1'b1;
                        res_data_next  = '0;
                        state_next     = DONE;
                    end
                end
            end
            ISSUE, WAIT: begin
                // Result beats timeout, timeout beats the issue handshake.
                if (sel_out_valid) begin
                    res_data_next      = slice[sel_idx];
                    res_valid_next     = 1'b1;
                    res_err_next       = 1'b0;
                    unit_in_valid_next = '0;
                    state_next         = DONE;
                end else if (timeout_hit) begin
                    res_data_next      = '0;
                    res_valid_next     = 1'b1;
                    res_err_next       = 1'b1;
                    unit_in_valid_next = '0;
                    state_next         = DONE;
                end else if ((state_reg == ISSUE) && sel_in_ready) begin
                    unit_in_valid_next = '0;
                    state_next         = WAIT;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_next = 1'b0;
                    res_err_next   = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready     = (state_reg == IDLE);
    assign bus.busy          = (state_reg != IDLE);
    assign bus.unit_in_valid = unit_in_valid_reg;
    assign bus.res_valid     = res_valid_reg;
    assign bus.res_data      = res_data_reg;
    assign bus.res_err       = res_err_reg;
endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch; the timeout scenario runs only with FPU_DISPATCH_TIMEOUT_EN.
module tb_fpu_dispatch;
    import fpu_pkg::*;

    localparam int NU = 9;
    localparam int DW = 32;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fpu_dispatch_if #(.NUM_UNITS(NU), .DATA_W(DW)) bus ();

    fpu_dispatch #(.NUM_UNITS(NU), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_units();
        bus.unit_in_ready  = '0;
        bus.unit_out_valid = '0;
        bus.unit_out_data  = '0;
    endtask

    task automatic request(input logic [NU-1:0] op);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        step();
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
    endtask

    task automatic res_handshake();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.res_ready = 1'b0;
        clear_units();
        #22 rst = 1'b0;
        #1;

        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_res_data", 64'(bus.res_data), 64'd0);
        check("rst_res_err", 64'(bus.res_err), 64'd0);
        check("rst_uiv", 64'(bus.unit_in_valid), 64'd0);

        // fmul: ready one cycle after issue, result three cycles later
        request(9'b000000100);
        check("mul_uiv", 64'(bus.unit_in_valid), 64'h004);
        check("mul_req_ready", 64'(bus.req_ready), 64'd0);
        bus.unit_in_ready[FPU_MUL] = 1'b1;
        step();
        bus.unit_in_ready[FPU_MUL] = 1'b0;
        check("mul_uiv_drop", 64'(bus.unit_in_valid), 64'd0);
        step();
        step();
        check("mul_wait_rv", 64'(bus.res_valid), 64'd0);
        bus.unit_out_valid[FPU_MUL] = 1'b1;
        bus.unit_out_data[FPU_MUL*DW +: DW] = 32'h40800000;
        step();
        clear_units();
        check("mul_rv", 64'(bus.res_valid), 64'd1);
        check("mul_data", 64'(bus.res_data), 64'h40800000);
        check("mul_err", 64'(bus.res_err), 64'd0);
        res_handshake();
        check("mul_idle_ready", 64'(bus.req_ready), 64'd1);
        check("mul_idle_rv", 64'(bus.res_valid), 64'd0);
        check("mul_data_kept", 64'(bus.res_data), 64'h40800000);

        // fmul with a stalled core and a second request waiting
        request(9'b000000100);
        bus.unit_in_ready[FPU_MUL]  = 1'b1;
        bus.unit_out_valid[FPU_MUL] = 1'b1;
        bus.unit_out_data[FPU_MUL*DW +: DW] = 32'h41200000;
        step();
        clear_units();
        bus.req_valid = 1'b1;
        bus.req_op    = 9'b000000100;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall_rv_%0d", i), 64'(bus.res_valid), 64'd1);
            check($sformatf("stall_data_%0d", i), 64'(bus.res_data), 64'h41200000);
            check($sformatf("stall_uiv_%0d", i), 64'(bus.unit_in_valid), 64'd0);
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("b2b_idle_ready", 64'(bus.req_ready), 64'd1);
        check("b2b_not_taken", 64'(bus.unit_in_valid), 64'd0);
        step();
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        check("b2b_taken", 64'(bus.unit_in_valid), 64'h004);
        bus.unit_in_ready[FPU_MUL]  = 1'b1;
        bus.unit_out_valid[FPU_MUL] = 1'b1;
        bus.unit_out_data[FPU_MUL*DW +: DW] = 32'h41000000;
        step();
        clear_units();
        check("b2b_data", 64'(bus.res_data), 64'h41000000);
        res_handshake();

        // bad opcodes: multi-hot then zero
        request(9'b000000110);
        check("mh_rv", 64'(bus.res_valid), 64'd1);
        check("mh_err", 64'(bus.res_err), 64'd1);
        check("mh_data", 64'(bus.res_data), 64'd0);
        check("mh_uiv", 64'(bus.unit_in_valid), 64'd0);
        res_handshake();
        check("mh_err_clr", 64'(bus.res_err), 64'd0);
        request(9'b000000000);
        check("zero_rv", 64'(bus.res_valid), 64'd1);
        check("zero_err", 64'(bus.res_err), 64'd1);
        check("zero_uiv", 64'(bus.unit_in_valid), 64'd0);
        res_handshake();

        // fabs: ready and result on the first issue edge
        request(9'b000100000);
        check("abs_uiv", 64'(bus.unit_in_valid), 64'h020);
        bus.unit_in_ready[FPU_ABS]  = 1'b1;
        bus.unit_out_valid[FPU_ABS] = 1'b1;
        bus.unit_out_data[FPU_ABS*DW +: DW] = 32'h3F800000;
        step();
        clear_units();
        check("abs_rv", 64'(bus.res_valid), 64'd1);
        check("abs_data", 64'(bus.res_data), 64'h3F800000);
        check("abs_uiv_drop", 64'(bus.unit_in_valid), 64'd0);
        res_handshake();

        // fadd in WAIT while fsub pulses a stray result
        request(9'b000000001);
        bus.unit_in_ready[FPU_ADD] = 1'b1;
        step();
        clear_units();
        bus.unit_out_valid[FPU_SUB] = 1'b1;
        bus.unit_in_ready[FPU_SUB]  = 1'b1;
        bus.unit_out_data[FPU_SUB*DW +: DW] = 32'hDEADBEEF;
        step();
        clear_units();
        check("add_stray_rv", 64'(bus.res_valid), 64'd0);
        check("add_stray_busy", 64'(bus.busy), 64'd1);
        bus.unit_out_valid[FPU_ADD] = 1'b1;
        bus.unit_out_data[FPU_ADD*DW +: DW] = 32'h40400000;
        bus.unit_out_data[FPU_SUB*DW +: DW] = 32'hDEADBEEF;
        step();
        clear_units();
        check("add_data", 64'(bus.res_data), 64'h40400000);
        res_handshake();

        // async reset while a unit still holds issue valid
        request(9'b000001000);
        #3 rst = 1'b1;
        #1;
        check("rst_issue_uiv", 64'(bus.unit_in_valid), 64'd0);
        check("rst_issue_ready", 64'(bus.req_ready), 64'd1);
        rst = 1'b0;

        // async reset mid-WAIT
        request(9'b000001000);
        bus.unit_in_ready[FPU_DIV] = 1'b1;
        step();
        clear_units();
        check("div_wait_busy", 64'(bus.busy), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("rst_wait_uiv", 64'(bus.unit_in_valid), 64'd0);
        check("rst_wait_rv", 64'(bus.res_valid), 64'd0);
        check("rst_wait_ready", 64'(bus.req_ready), 64'd1);
        rst = 1'b0;

`ifdef FPU_DISPATCH_TIMEOUT_EN
        // fdiv never answers: error 16 cycles after the issue handshake
        request(9'b000001000);
        bus.unit_in_ready[FPU_DIV] = 1'b1;
        step();
        clear_units();
        for (int i = 0; i < 15; i++) step();
        check("to_before_rv", 64'(bus.res_valid), 64'd0);
        step();
        check("to_rv", 64'(bus.res_valid), 64'd1);
        check("to_err", 64'(bus.res_err), 64'd1);
        check("to_data", 64'(bus.res_data), 64'd0);
        res_handshake();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
